// File: rtl/viterbi_pkg.sv
// Shared constants, generator defaults and FSM encoding for the hard-decision
// Viterbi decoder tile.
package viterbi_pkg;

    localparam int VIT_K        = 5;
    localparam int VIT_MAX_SYMS = 32;
    localparam int VIT_NSTATES  = 1 << (VIT_K - 1);
    localparam int MW           = 8;

    // Generator for symbol bit 1, right-aligned in 7 bits.
    function automatic logic [6:0] def_g0(input int k);
        case (k)
            3:       return 7'b0000111;
            7:       return 7'b1111001;
            default: return 7'b0010011;
        endcase
    endfunction

    // Generator for symbol bit 0.
    function automatic logic [6:0] def_g1(input int k);
        case (k)
            3:       return 7'b0000101;
            7:       return 7'b1011011;
            default: return 7'b0011101;
        endcase
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACS,
        ST_TRACE,
        ST_OUT
    } vit_state_t;

endpackage

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select for one trellis state: both predecessors of s are scored
// against the received symbol and the cheaper one survives (ties keep b=0).
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int K = VIT_K,
    parameter logic [K-1:0] G0 = K'(def_g0(K)),
    parameter logic [K-1:0] G1 = K'(def_g1(K))
) (
    input  logic [K-2:0]  s,
    input  logic [MW-1:0] pm0,
    input  logic [MW-1:0] pm1,
    input  logic [1:0]    rx,
    output logic [MW-1:0] pm_new,
    output logic          surv
);

    // The encoder register for predecessor {b, s[K-2:1]} with input s[0] is {b, s}.
    function automatic logic [MW-1:0] cand(input logic b, input logic [K-2:0] st,
                                           input logic [1:0] sym, input logic [MW-1:0] pm);
        logic [K-1:0] r;
        logic [1:0]   d;
        logic [MW:0]  sum;
        r   = {b, st};
        d   = {^(r & G0), ^(r & G1)} ^ sym;
        sum = {1'b0, pm} + {{MW{1'b0}}, d[1]} + {{MW{1'b0}}, d[0]};
        return sum[MW] ? '1 : sum[MW-1:0];
    endfunction

    logic [MW-1:0] c0, c1;

    always_comb begin
        c0     = cand(1'b0, s, rx, pm0);
        c1     = cand(1'b1, s, rx, pm1);
        surv   = (c1 < c0);
        pm_new = surv ? c1 : c0;
    end

endmodule

// File: rtl/ashvin_viterbi.sv
// Serial hard-decision Viterbi decoder behind the 8-bit tile pins: load symbol
// bytes, decode one state per cycle, trace back, then hand out decoded bytes.
module ashvin_viterbi
    import viterbi_pkg::*;
#(
    parameter int K = VIT_K,
    parameter logic [K-1:0] G0 = K'(def_g0(K)),
    parameter logic [K-1:0] G1 = K'(def_g1(K)),
    parameter int MAX_SYMS = VIT_MAX_SYMS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NS = 1 << (K - 1);
    localparam int SW = K - 1;
    localparam int NW = $clog2(MAX_SYMS + 1);
    localparam int TW = $clog2(MAX_SYMS);

    vit_state_t state, nxt;

    logic [NW-1:0] nsym, ptr, nsym_acc, nbytes;
    logic [TW-1:0] t;
    logic [SW-1:0] s, ts, cs, best_s;
    logic [MW-1:0] best_m, pm_new;
    logic          cur, tr_first, frame_done, surv_bit;

    logic [MAX_SYMS-1:0][1:0]    sym_mem;
    logic [MAX_SYMS-1:0][NS-1:0] surv_mem;
    logic [MAX_SYMS-1:0]         dec;
    logic [1:0][NS-1:0][MW-1:0]  pm;

    logic byte_valid, start, read_ack;
    logic loading, busy, out_valid, ready, accept, go;
    logic acs_last, step_last, last_byte;
    logic [SW-1:0] pred0, pred1;
    logic [7:0]    out_byte;

    assign byte_valid = ui_in[0];
    assign start      = ui_in[3];
    assign read_ack   = ui_in[4];

    logic unused_pins;
    assign unused_pins = &{1'b0, ena, ui_in[7:5], ui_in[2:1]};

    assign ready     = loading && (int'(nsym) + 4 <= MAX_SYMS);
    assign accept    = byte_valid && ready;
    assign nsym_acc  = accept ? nsym + NW'(4) : nsym;
    assign go        = loading && start && (nsym_acc != '0);
    assign nbytes    = NW'((int'(nsym) + 7) / 8);
    assign acs_last  = (s == SW'(NS - 1));
    assign step_last = (NW'(t) == nsym - NW'(1));
    assign last_byte = (ptr == nbytes - NW'(1));
    assign pred0     = {1'b0, s[SW-1:1]};
    assign pred1     = {1'b1, s[SW-1:1]};

    viterbi_acs_unit #(.K(K), .G0(G0), .G1(G1)) u_acs (
        .s      (s),
        .pm0    (pm[cur][pred0]),
        .pm1    (pm[cur][pred1]),
        .rx     (sym_mem[t]),
        .pm_new (pm_new),
        .surv   (surv_bit)
    );

    // Lowest-index state holding the minimum final metric seeds the traceback.
    always_comb begin
        best_s = '0;
        best_m = pm[cur][0];
        for (int i = 1; i < NS; i++) begin
            if (pm[cur][SW'(i)] < best_m) begin
                best_m = pm[cur][SW'(i)];
                best_s = SW'(i);
            end
        end
    end

    assign cs = tr_first ? best_s : ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (go) nxt = ST_ACS; else if (accept) nxt = ST_LOAD;
            ST_LOAD:  if (go) nxt = ST_ACS;
            ST_ACS:   if (acs_last && step_last) nxt = ST_TRACE;
            ST_TRACE: if (t == '0) nxt = ST_OUT;
            ST_OUT:   if (read_ack && last_byte) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        loading   = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE, ST_LOAD: loading   = 1'b1;
            ST_ACS, ST_TRACE: busy      = 1'b1;
            ST_OUT:           out_valid = 1'b1;
            default:          loading   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nsym       <= '0;
            ptr        <= '0;
            t          <= '0;
            s          <= '0;
            ts         <= '0;
            cur        <= 1'b0;
            tr_first   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_LOAD: begin
                    nsym <= nsym_acc;
                    if (accept) frame_done <= 1'b0;
                    if (go) begin
                        t   <= '0;
                        s   <= '0;
                        cur <= 1'b0;
                        ptr <= '0;
                    end
                end
                ST_ACS: begin
                    s <= s + SW'(1);
                    if (acs_last) begin
                        cur <= ~cur;
                        if (step_last) tr_first <= 1'b1;
                        else           t <= t + TW'(1);
                    end
                end
                ST_TRACE: begin
                    tr_first <= 1'b0;
                    ts       <= {surv_mem[t][cs], cs[SW-1:1]};
                    if (t != '0) t <= t - TW'(1);
                    else         frame_done <= 1'b1;
                end
                ST_OUT: begin
                    if (read_ack) begin
                        if (last_byte) begin
                            ptr  <= '0;
                            nsym <= '0;
                        end else begin
                            ptr <= ptr + NW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; reads are always bounded by nsym.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++)
                sym_mem[TW'(nsym) + TW'(i)] <= uio_in[2*i +: 2];
        end
        if (go) begin
            for (int i = 0; i < NS; i++)
                pm[0][SW'(i)] <= (i == 0) ? '0 : '1;
        end
        if (state == ST_ACS) begin
            pm[~cur][s]    <= pm_new;
            surv_mem[t][s] <= surv_bit;
        end
        if (state == ST_TRACE) dec[t] <= cs[0];
    end

    always_comb begin
        out_byte = '0;
        for (int j = 0; j < 8; j++) begin
            if (int'(ptr) * 8 + j < int'(nsym))
                out_byte[j] = dec[TW'(int'(ptr) * 8 + j)];
        end
    end

    assign uo_out  = {3'b000, frame_done, busy, 1'b0, out_valid, ready & ~rst};
    assign uio_out = out_valid ? out_byte : 8'h00;
    assign uio_oe  = {8{out_valid}};

endmodule

// File: tb/tb_ashvin_viterbi.sv
// Directed and random frames for the K=5 decoder; expectations come from a
// plain software encoder and the original data bits.
module tb_ashvin_viterbi;

    localparam logic [4:0] TG0 = 5'b10011;
    localparam logic [4:0] TG1 = 5'b11101;

    logic       clk = 1'b0;
    logic       rst, ena;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    int checks = 0;
    int errors = 0;
    logic [1:0] syms [32];

    ashvin_viterbi dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ui_in  = 8'h01;
        uio_in = b;
        @(negedge clk);
        ui_in  = 8'h00;
    endtask

    task automatic pulse_start();
        ui_in = 8'h08;
        @(negedge clk);
        ui_in = 8'h00;
    endtask

    // Encode, optionally corrupt one symbol, load, decode and read back.
    task automatic run_frame(input logic [31:0] data, input int n, input int flip, input bit poke);
        logic [4:0] r;
        logic [3:0] st;
        logic [7:0] exp_b;
        int cyc, nbytes;
        st = '0;
        for (int i = 0; i < n; i++) begin
            r       = {st, data[i]};
            syms[i] = {^(r & TG0), ^(r & TG1)};
            st      = r[3:0];
        end
        if (flip >= 0) syms[flip][0] = ~syms[flip][0];
        for (int b = 0; b < n / 4; b++) begin
            send_byte({syms[4*b+3], syms[4*b+2], syms[4*b+1], syms[4*b]});
            if (b == 0) check("frame_done_clr", uo_out[4], 1'b0);
        end
        check("ready_after_load", uo_out[0], (n < 32) ? 1'b1 : 1'b0);
        if (n == 32) send_byte(8'h5A);
        pulse_start();
        check("busy_on_start", uo_out[3], 1'b1);
        check("ready_off_busy", uo_out[0], 1'b0);
        if (poke) send_byte(8'hFF);
        cyc = 0;
        while (uo_out[3] && cyc < 17 * n + 4) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_fall", uo_out[3], 1'b0);
        check("frame_done_set", uo_out[4], 1'b1);
        nbytes = (n + 7) / 8;
        for (int k = 0; k < nbytes; k++) begin
            exp_b = '0;
            for (int j = 0; j < 8; j++)
                if (8*k + j < n) exp_b[j] = data[8*k + j];
            check("out_valid", uo_out[1], 1'b1);
            check("uio_oe_on", uio_oe, 8'hFF);
            check($sformatf("dec_byte%0d_n%0d", k, n), uio_out, exp_b);
            ui_in = 8'h10;
            @(negedge clk);
            ui_in = 8'h00;
        end
        check("out_valid_off", uo_out[1], 1'b0);
        check("uio_oe_off", uio_oe, 8'h00);
        check("idle_pins", uo_out, 8'h11);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; ui_in = '0; uio_in = '0;
        repeat (2) @(negedge clk);
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", uo_out, 8'h01);

        pulse_start();
        check("start_empty_ignored", uo_out, 8'h01);

        run_frame(32'h0, 8, -1, 1'b0);
        run_frame(32'hFF, 8, -1, 1'b0);
        run_frame(32'hAA, 8, -1, 1'b0);
        run_frame(32'h55, 8, -1, 1'b0);
        run_frame(32'hB4, 8, -1, 1'b1);
        run_frame(32'hACE2, 16, -1, 1'b0);
        run_frame(32'hACE2, 16, 3, 1'b0);
        run_frame($urandom, 32, -1, 1'b0);

        // Abort mid-decode, then a fresh frame must decode cleanly.
        send_byte(8'h12);
        send_byte(8'h34);
        pulse_start();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_uo_out", uo_out, 8'h00);
        check("abort_uio_out", uio_out, 8'h00);
        check("abort_uio_oe", uio_oe, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", uo_out, 8'h01);
        run_frame(32'hB4, 8, -1, 1'b0);

        for (int f = 0; f < 10; f++)
            run_frame($urandom, 4 * $urandom_range(1, 8), -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
